ila_sequencer: RTL and testbench
================================

Name: ila_sequencer

Overview:
- Generates the Initial Lane Alignment (ILA) octet stream for one TX lane while the link controller is in its lane-alignment state.
- Produces one octet per clk, with a K-flag, for the 8b/10b encoder mux input "ILA".
- Each multiframe is framed by /R/ (start) and /A/ (end). The second multiframe carries /Q/ and the 14 link-configuration octets.
- Started on an LMFC boundary and aborted on a sync request, both driven by the link controller.

Parameters:
- CFG_OCTETS, 14, number of link-configuration octets carried in multiframe 1.
- OCT_CNT_W, 10, width of the octet-in-multiframe counter (F*K up to 1024).

Ports:
- clk  in  1  device clock, one octet per cycle.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  single-cycle pulse: begin ILA; asserted by the controller on an LMFC boundary.
- i_abort  in  1  sync request seen: terminate the sequence.
- i_F  in  8  octets per frame, encoding value-1 (1..256).
- i_K  in  5  frames per multiframe, encoding value-1 (1..32).
- i_ila_multiframe_length  in  8  multiframes in the ILA, encoding value-1 (1..256).
- i_ila_config  in  112  config octets; octet n is bits [8n+7:8n].
- o_data  out  8  ILA octet.
- o_is_k  out  1  o_data is a control character.
- o_valid  out  1  o_data/o_is_k are meaningful.
- o_done  out  1  one-cycle pulse coincident with the final /A/.
- o_cfg_err  out  1  F*K < 17 at the last i_start (sticky until the next i_start).

Behaviour:
- Reset: state IDLE, all counters 0, o_data=0, o_is_k=0, o_valid=0, o_done=0, o_cfg_err=0.
- FSM states:
  - IDLE: o_valid=0.
  - RUN: o_valid=1.
- On i_start in IDLE:
  - Latch F+1, K+1, length+1 and i_ila_config.
  - Compute octets-per-multiframe MF = (F+1)*(K+1), 10-bit result, maximum 1024 held as 0 in a 10-bit value with 11-bit compare.
  - If MF<17: set o_cfg_err=1 and remain in IDLE.
  - Otherwise clear o_cfg_err and enter RUN.
- Latency: the first octet appears on the registered outputs the cycle after i_start.
- Counters:
  - m = octet index in the multiframe, 0..MF-1, wraps to 0.
  - mf = multiframe index, 0..length; increments when m wraps.
- Output per octet:
  - m=0: 0x1C (K28.0 /R/), k=1.
  - m=MF-1: 0x7C (K28.3 /A/), k=1.
  - mf=1, m=1: 0x9C (K28.4 /Q/), k=1.
  - mf=1, m=2..15: config octet (m-2), k=0.
  - All other octets: m[7:0] (ramp filler), k=0.
- Termination: when mf=length and m=MF-1, o_done=1 for that cycle. Next cycle is IDLE with o_valid=0.
- i_abort:
  - In RUN: next cycle IDLE, o_valid=0, o_done not pulsed, counters cleared.
  - In IDLE: no effect.
- Simultaneous i_start and i_abort: abort wins; stay IDLE and do not update o_cfg_err.
- i_start during RUN: ignored; config latches are unchanged.
- rst asserted mid-sequence: returns to reset values on the next edge.
- Config and size inputs may change during RUN without effect.

Optional Feature:
- Macro ILA_CHECKSUM_EN.
- Defined: config octet 13 (FCHK) is replaced by the sum of latched config octets 0..12 mod 256, computed at i_start and registered.
- Undefined: octet 13 is passed from i_ila_config unchanged.

Decomposition:
- Package jesd_ila_pkg:
  - K-character constants K_R=8'h1C, K_A=8'h7C, K_Q=8'h9C.
  - FSM state encoding (IDLE, RUN).
  - MIN_MF_OCTETS=17.
  - CFG_OCTETS.
- Sub-module ila_position_counter: octet/multiframe counters with wrap, last-octet and last-multiframe flags; inputs clear, enable, MF, length.

Test Plan:
- Base sequence, F=2, K=16, 4 multiframes (i_F=1, i_K=15, len=3), i_start at t0:
  - 128 valid octets t1..t128.
  - Octet 0 = 0x1C k=1, octet 31 = 0x7C k=1, octet 32 = 0x1C, octet 33 = 0x9C k=1.
  - Octets 34..47 = config 0..13, octet 48 = 0x10.
  - o_done only at t128; o_valid=0 at t129.
- Size check, i_F=0, i_K=15 (MF=16): o_cfg_err=1, o_valid stays 0. Then i_F=0, i_K=16 (MF=17): the sequence runs and /A/ lands at m=16.
- Abort at octet 40 of the base sequence: o_valid=0 on the next cycle, no o_done. A fresh i_start restarts at 0x1C.
- Simultaneous start+abort in IDLE: nothing is output. i_start at octet 10 of a run: the sequence is unaffected.
- rst pulse mid-run: all outputs zero the next cycle. A subsequent i_start produces the full sequence.
- With ILA_CHECKSUM_EN, config octets 0..12 = 1..13: octet 47 = 0x5B. Without the macro: octet 47 = i_ila_config[111:104].

Source files
------------

// File: rtl/jesd_ila_pkg.sv
// Shared definitions for the ILA octet generator.
//   K_R / K_A / K_Q : control characters framing and marking ILA multiframes.
//   ila_state_e     : sequencer FSM states.
//   ila_fchk        : FCHK checksum over link-configuration octets 0..12.
package jesd_ila_pkg;

    localparam int unsigned CFG_OCTETS    = 14;
    localparam int unsigned OCT_CNT_W     = 10;
    localparam int unsigned MIN_MF_OCTETS = 17;

    localparam logic [7:0] K_R = 8'h1C;  // K28.0, multiframe start
    localparam logic [7:0] K_A = 8'h7C;  // K28.3, multiframe end
    localparam logic [7:0] K_Q = 8'h9C;  // K28.4, config data follows

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } ila_state_e;

    // Sum of every config octet except the last (which is the checksum slot), mod 256.
    function automatic logic [7:0] ila_fchk(input logic [8*CFG_OCTETS-1:0] cfg);
        logic [7:0] sum;
        sum = '0;
        for (int i = 0; i < CFG_OCTETS - 1; i++) begin
            sum = sum + cfg[8*i +: 8];
        end
        return sum;
    endfunction

endpackage

// File: rtl/ila_position_counter.sv
// Octet-in-multiframe and multiframe counters for the ILA sequencer.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   i_clear        : force both counters to 0 (has priority over i_enable)
//   i_enable       : advance one octet
//   i_mf_len       : octets per multiframe; 0 encodes 1024
//   i_len          : index of the final multiframe
//   o_m, o_mf      : current octet / multiframe index
//   o_last_oct     : o_m is the last octet of the multiframe
//   o_last_mf      : o_mf is the final multiframe
module ila_position_counter
    import jesd_ila_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_enable,
    input  logic [OCT_CNT_W-1:0] i_mf_len,
    input  logic [7:0]           i_len,
    output logic [OCT_CNT_W-1:0] o_m,
    output logic [7:0]           o_mf,
    output logic                 o_last_oct,
    output logic                 o_last_mf
);

    logic [OCT_CNT_W-1:0] m_q, m_d;
    logic [7:0]           mf_q, mf_d;
    logic [OCT_CNT_W-1:0] m_last;

    // 0 - 1 wraps to 1023, so a 1024-octet multiframe needs no special case.
    assign m_last     = i_mf_len - OCT_CNT_W'(1);
    assign o_last_oct = (m_q == m_last);
    assign o_last_mf  = (mf_q == i_len);
    assign o_m        = m_q;
    assign o_mf       = mf_q;

    always_comb begin
        m_d  = m_q;
        mf_d = mf_q;
        if (i_clear) begin
            m_d  = '0;
            mf_d = '0;
        end else if (i_enable) begin
            if (o_last_oct) begin
                m_d  = '0;
                mf_d = mf_q + 8'd1;
            end else begin
                m_d  = m_q + OCT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q  <= '0;
            mf_q <= '0;
        end else begin
            m_q  <= m_d;
            mf_q <= mf_d;
        end
    end

endmodule

// File: rtl/ila_sequencer.sv
// Initial Lane Alignment octet generator for one TX lane.
// Emits one octet per clk (registered) from the cycle after an accepted i_start
// until the final /A/ of the last multiframe, or until i_abort.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   i_start, i_abort        : begin on LMFC boundary / terminate on sync request
//   i_F, i_K                : octets per frame - 1, frames per multiframe - 1
//   i_ila_multiframe_length : multiframes in the ILA - 1
//   i_ila_config            : 14 link-configuration octets, octet n at [8n+7:8n]
//   o_data, o_is_k, o_valid : octet stream to the 8b/10b encoder mux
//   o_done                  : pulse with the final /A/
//   o_cfg_err               : F*K < 17 at the last accepted i_start
// Build option: define ILA_CHECKSUM_EN to replace config octet 13 with a computed FCHK.
module ila_sequencer
    import jesd_ila_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic [7:0]   i_F,
    input  logic [4:0]   i_K,
    input  logic [7:0]   i_ila_multiframe_length,
    input  logic [111:0] i_ila_config,
    output logic [7:0]   o_data,
    output logic         o_is_k,
    output logic         o_valid,
    output logic         o_done,
    output logic         o_cfg_err
);

    ila_state_e state_q, state_d;

    logic [OCT_CNT_W-1:0] mf_len_q;
    logic [7:0]           len_q;
    logic [111:0]         cfg_q;
`ifdef ILA_CHECKSUM_EN
    logic [7:0]           fchk_q;
`endif

    logic [7:0] data_q, data_d;
    logic       is_k_q, is_k_d;
    logic       valid_q, valid_d;
    logic       done_q, done_d;
    logic       cfg_err_q, cfg_err_d;

    logic [8:0]  f1;
    logic [5:0]  k1;
    logic [14:0] mf_prod;
    logic        size_ok;
    logic        start_acc;
    logic        latch_cfg;

    logic                 cnt_clear, cnt_en;
    logic [OCT_CNT_W-1:0] cnt_mf_len;
    logic [7:0]           cnt_len;
    logic [OCT_CNT_W-1:0] cnt_m;
    logic [7:0]           cnt_mf;
    logic                 cnt_last_oct, cnt_last_mf;

    logic [3:0] cfg_idx;
    logic [7:0] cfg_oct;
    logic [7:0] oct_data;
    logic       oct_k;

    // Full-width product so 1024 compares correctly; only 10 bits are kept.
    assign f1        = {1'b0, i_F} + 9'd1;
    assign k1        = {1'b0, i_K} + 6'd1;
    assign mf_prod   = 15'(f1) * 15'(k1);
    assign size_ok   = (mf_prod >= 15'(MIN_MF_OCTETS));
    assign start_acc = i_start && !i_abort && (state_q == StIdle);

    // The start cycle advances the counter before the latches update, so feed it live sizes.
    assign cnt_mf_len = (state_q == StRun) ? mf_len_q : mf_prod[OCT_CNT_W-1:0];
    assign cnt_len    = (state_q == StRun) ? len_q : i_ila_multiframe_length;

    ila_position_counter u_pos (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (cnt_clear),
        .i_enable   (cnt_en),
        .i_mf_len   (cnt_mf_len),
        .i_len      (cnt_len),
        .o_m        (cnt_m),
        .o_mf       (cnt_mf),
        .o_last_oct (cnt_last_oct),
        .o_last_mf  (cnt_last_mf)
    );

    // Octet content for the counter position.
    always_comb begin
        cfg_idx = 4'(cnt_m - OCT_CNT_W'(2));
        cfg_oct = cfg_q[{cfg_idx, 3'b000} +: 8];
`ifdef ILA_CHECKSUM_EN
        if (cfg_idx == 4'(CFG_OCTETS - 1)) begin
            cfg_oct = fchk_q;
        end
`endif
        oct_data = cnt_m[7:0];
        oct_k    = 1'b0;
        if (cnt_m == '0) begin
            oct_data = K_R;
            oct_k    = 1'b1;
        end else if (cnt_last_oct) begin
            oct_data = K_A;
            oct_k    = 1'b1;
        end else if (cnt_mf == 8'd1 && cnt_m == OCT_CNT_W'(1)) begin
            oct_data = K_Q;
            oct_k    = 1'b1;
        end else if (cnt_mf == 8'd1 && cnt_m >= OCT_CNT_W'(2)
                     && cnt_m <= OCT_CNT_W'(CFG_OCTETS + 1)) begin
            oct_data = cfg_oct;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        latch_cfg = 1'b0;
        data_d    = '0;
        is_k_d    = 1'b0;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        cfg_err_d = cfg_err_q;
        unique case (state_q)
            StIdle: begin
                cnt_clear = 1'b1;
                if (start_acc) begin
                    latch_cfg = 1'b1;
                    cfg_err_d = !size_ok;
                    if (size_ok) begin
                        // Octet 0 is always /R/; emit it now and step the counter to 1.
                        state_d   = StRun;
                        cnt_clear = 1'b0;
                        cnt_en    = 1'b1;
                        data_d    = K_R;
                        is_k_d    = 1'b1;
                        valid_d   = 1'b1;
                    end
                end
            end
            StRun: begin
                if (i_abort) begin
                    state_d   = StIdle;
                    cnt_clear = 1'b1;
                end else begin
                    data_d  = oct_data;
                    is_k_d  = oct_k;
                    valid_d = 1'b1;
                    cnt_en  = 1'b1;
                    if (cnt_last_oct && cnt_last_mf) begin
                        done_d    = 1'b1;
                        state_d   = StIdle;
                        cnt_clear = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mf_len_q  <= '0;
            len_q     <= '0;
            cfg_q     <= '0;
`ifdef ILA_CHECKSUM_EN
            fchk_q    <= '0;
`endif
            data_q    <= '0;
            is_k_q    <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            is_k_q    <= is_k_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            if (latch_cfg) begin
                mf_len_q <= mf_prod[OCT_CNT_W-1:0];
                len_q    <= i_ila_multiframe_length;
                cfg_q    <= i_ila_config;
`ifdef ILA_CHECKSUM_EN
                fchk_q   <= ila_fchk(i_ila_config);
`endif
            end
        end
    end

    assign o_data    = data_q;
    assign o_is_k    = is_k_q;
    assign o_valid   = valid_q;
    assign o_done    = done_q;
    assign o_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_ila_sequencer.sv
module tb_ila_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_start = 1'b0;
    logic         i_abort = 1'b0;
    logic [7:0]   i_F = '0;
    logic [4:0]   i_K = '0;
    logic [7:0]   i_ila_multiframe_length = '0;
    logic [111:0] i_ila_config = '0;
    logic [7:0]   o_data;
    logic         o_is_k;
    logic         o_valid;
    logic         o_done;
    logic         o_cfg_err;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] cap [1024];

    ila_sequencer dut (
        .clk                     (clk),
        .rst                     (rst),
        .i_start                 (i_start),
        .i_abort                 (i_abort),
        .i_F                     (i_F),
        .i_K                     (i_K),
        .i_ila_multiframe_length (i_ila_multiframe_length),
        .i_ila_config            (i_ila_config),
        .o_data                  (o_data),
        .o_is_k                  (o_is_k),
        .o_valid                 (o_valid),
        .o_done                  (o_done),
        .o_cfg_err               (o_cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: config octet n as the link carries it.
    function automatic logic [7:0] ref_cfg(input logic [111:0] cfg, input int n);
        logic [111:0] t;
        int sum;
        t = cfg >> (8 * n);
`ifdef ILA_CHECKSUM_EN
        if (n == 13) begin
            sum = 0;
            for (int j = 0; j < 13; j++) begin
                t = cfg >> (8 * j);
                sum += int'(t[7:0]);
            end
            return 8'(sum % 256);
        end
`endif
        return t[7:0];
    endfunction

    // Reference: octet m of multiframe mf in a multiframe of mfo octets.
    task automatic ref_octet(input int m, input int mf, input int mfo, input logic [111:0] cfg,
                             output logic [7:0] d, output logic k);
        k = 1'b0;
        if (m == 0) begin
            d = 8'h1C; k = 1'b1;
        end else if (m == mfo - 1) begin
            d = 8'h7C; k = 1'b1;
        end else if (mf == 1 && m == 1) begin
            d = 8'h9C; k = 1'b1;
        end else if (mf == 1 && m >= 2 && m <= 15) begin
            d = ref_cfg(cfg, m - 2);
        end else begin
            d = 8'(m % 256);
        end
    endtask

    task automatic run_seq(input logic [7:0] f, input logic [4:0] k, input logic [7:0] len,
                           input logic [111:0] cfg, input logic exp_err,
                           input int abort_at, input int restart_at);
        int mfo, total;
        logic [7:0] ed;
        logic ek;
        mfo   = (int'(f) + 1) * (int'(k) + 1);
        total = mfo * (int'(len) + 1);
        i_F = f; i_K = k; i_ila_multiframe_length = len; i_ila_config = cfg;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        // Size/config inputs changing during the run must not matter.
        i_F = 8'($urandom); i_K = 5'($urandom); i_ila_multiframe_length = 8'($urandom);
        i_ila_config = ~cfg;
        check("cfg_err", o_cfg_err, exp_err);
        if (exp_err) begin
            check("err_valid", o_valid, 0);
            step();
            check("err_valid2", o_valid, 0);
            return;
        end
        for (int i = 0; i < total; i++) begin
            ref_octet(i % mfo, i / mfo, mfo, cfg, ed, ek);
            cap[i] = o_data;
            check($sformatf("data[%0d]", i), o_data, ed);
            check($sformatf("is_k[%0d]", i), o_is_k, ek);
            check($sformatf("valid[%0d]", i), o_valid, 1);
            check($sformatf("done[%0d]", i), o_done, (i == total - 1) ? 1 : 0);
            if (i == abort_at) begin
                i_abort = 1'b1;
                step();
                i_abort = 1'b0;
                check("abort_valid", o_valid, 0);
                check("abort_done", o_done, 0);
                step();
                check("abort_valid2", o_valid, 0);
                return;
            end
            if (i == restart_at) begin
                i_start = 1'b1; i_F = 8'd0; i_K = 5'd0;
            end
            step();
            i_start = 1'b0;
        end
        check("end_valid", o_valid, 0);
        check("end_done", o_done, 0);
    endtask

    typedef struct {
        logic [7:0] f;
        logic [4:0] k;
        logic [7:0] len;
        logic       exp_err;
    } size_vec_t;

    initial begin
        size_vec_t tbl [8];
        logic [111:0] base_cfg;
        logic [127:0] r;
        logic [7:0] rf, rlen;
        logic [4:0] rk;
        int rmfo, rab;

        tbl[0] = '{8'd0,   5'd15, 8'd0, 1'b1};  // MF=16
        tbl[1] = '{8'd0,   5'd16, 8'd0, 1'b0};  // MF=17
        tbl[2] = '{8'd1,   5'd7,  8'd1, 1'b1};  // MF=16
        tbl[3] = '{8'd16,  5'd0,  8'd1, 1'b0};  // MF=17
        tbl[4] = '{8'd3,   5'd3,  8'd0, 1'b1};  // MF=16
        tbl[5] = '{8'd0,   5'd0,  8'd0, 1'b1};  // MF=1
        tbl[6] = '{8'd255, 5'd3,  8'd0, 1'b0};  // MF=1024
        tbl[7] = '{8'd4,   5'd3,  8'd1, 1'b0};  // MF=20

        base_cfg = '0;
        for (int n = 0; n < 13; n++) base_cfg[8*n +: 8] = 8'(n + 1);
        base_cfg[111:104] = 8'hEE;

        step(); step();
        check("rst_data", o_data, 0);
        check("rst_is_k", o_is_k, 0);
        check("rst_valid", o_valid, 0);
        check("rst_done", o_done, 0);
        check("rst_cfg_err", o_cfg_err, 0);
        rst = 1'b0;
        step();

        // Base sequence: F=2, K=16, 4 multiframes.
        run_seq(8'd1, 5'd15, 8'd3, base_cfg, 1'b0, -1, -1);
        check("oct0", cap[0], 8'h1C);
        check("oct31", cap[31], 8'h7C);
        check("oct32", cap[32], 8'h1C);
        check("oct33", cap[33], 8'h9C);
        check("oct34", cap[34], 8'h01);
`ifdef ILA_CHECKSUM_EN
        check("oct47", cap[47], 8'h5B);
`else
        check("oct47", cap[47], 8'hEE);
`endif
        check("oct48", cap[48], 8'h10);
        check("oct127", cap[127], 8'h7C);

        // Size table.
        foreach (tbl[i]) begin
            run_seq(tbl[i].f, tbl[i].k, tbl[i].len, base_cfg, tbl[i].exp_err, -1, -1);
            step();
        end
        run_seq(8'd0, 5'd16, 8'd0, base_cfg, 1'b0, -1, -1);
        check("mf17_a", cap[16], 8'h7C);
        check("mf17_m15", cap[15], 8'h0F);

        // Abort at octet 40, then a fresh start.
        run_seq(8'd1, 5'd15, 8'd3, base_cfg, 1'b0, 40, -1);
        run_seq(8'd1, 5'd15, 8'd3, base_cfg, 1'b0, -1, -1);

        // Start+abort together in IDLE, with cfg_err already set.
        run_seq(8'd0, 5'd0, 8'd0, base_cfg, 1'b1, -1, -1);
        i_F = 8'd1; i_K = 5'd15; i_start = 1'b1; i_abort = 1'b1;
        step();
        i_start = 1'b0; i_abort = 1'b0;
        check("sa_valid", o_valid, 0);
        check("sa_cfg_err", o_cfg_err, 1);
        step();
        check("sa_valid2", o_valid, 0);

        // i_start during a run is ignored.
        run_seq(8'd1, 5'd15, 8'd3, base_cfg, 1'b0, -1, 10);

        // Reset mid-run.
        i_F = 8'd1; i_K = 5'd15; i_ila_multiframe_length = 8'd3; i_ila_config = base_cfg;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("mid_valid", o_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_data", o_data, 0);
        check("mrst_is_k", o_is_k, 0);
        check("mrst_valid", o_valid, 0);
        check("mrst_done", o_done, 0);
        check("mrst_cfg_err", o_cfg_err, 0);
        step();
        check("mrst_valid2", o_valid, 0);
        run_seq(8'd1, 5'd15, 8'd3, base_cfg, 1'b0, -1, -1);

        // Randomized runs against the reference.
        for (int t = 0; t < 8; t++) begin
            r    = {$urandom, $urandom, $urandom, $urandom};
            rf   = 8'($urandom_range(0, 7));
            rk   = 5'($urandom_range(0, 31));
            rlen = 8'($urandom_range(0, 3));
            rmfo = (int'(rf) + 1) * (int'(rk) + 1);
            rab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rmfo - 1)) : -1;
            run_seq(rf, rk, rlen, r[111:0], (rmfo < 17) ? 1'b1 : 1'b0, rab, -1);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
